// File: rtl/debounce_sync_pkg.sv
// debounce_sync_pkg
// Shared definitions for the debounce/synchronizer slice.
//   - FSM state encodings (2-bit, legacy-compatible constants)
//   - default depths for the synchronizer and the stability filter
// No ports; imported by debounce_sync and usable by any block that needs to
// decode the debouncer state.
package debounce_sync_pkg;

    // FSM state encodings. All four 2-bit codes are used.
    localparam logic [1:0] S_LOW       = 2'd0;
    localparam logic [1:0] S_RISE_WAIT = 2'd1;
    localparam logic [1:0] S_HIGH      = 2'd2;
    localparam logic [1:0] S_FALL_WAIT = 2'd3;

    // Default parameter values.
    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_STABLE_CYCLES = 4;

endpackage

// File: rtl/debounce_sync_chain.sv
// sync_chain
// SYNC_STAGES-deep flop chain that brings an asynchronous level into clk.
// Reusable ahead of any flip-flop input that is fed from outside the domain.
// Ports:
//   clk    in   system clock, rising-edge active
//   reset  in   asynchronous reset, active-low; clears every stage to 0
//   d      in   raw asynchronous level
//   q      out  d delayed by SYNC_STAGES rising edges
module sync_chain #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic stage_reg [SYNC_STAGES];

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                // First stage is the only flop that may go metastable.
                always_ff @(posedge clk or negedge reset) begin
                    if (!reset) begin
                        stage_reg[0] <= 1'b0;
                    end else begin
                        stage_reg[0] <= d;
                    end
                end
            end else begin : g_rest
                always_ff @(posedge clk or negedge reset) begin
                    if (!reset) begin
                        stage_reg[gi] <= 1'b0;
                    end else begin
                        stage_reg[gi] <= stage_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    assign q = stage_reg[SYNC_STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// debounce_sync
// Synchronizes a raw, possibly bouncing level input and only lets a change
// through once it has been seen on STABLE_CYCLES consecutive synchronized
// samples. Produces a clean level plus one-cycle rise/fall pulses.
// Ports:
//   clk    in   system clock, rising-edge active
//   reset  in   asynchronous reset, active-low
//   din    in   raw asynchronous level (switch, button)
//   dout   out  debounced level (decoded from the state register)
//   rise   out  one-cycle pulse on a debounced 0->1 change
//   fall   out  one-cycle pulse on a debounced 1->0 change
//   busy   out  high while a candidate change is being qualified
module debounce_sync
    import debounce_sync_pkg::*;
#(
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall,
    output logic busy
);

    // Derived width of the stability counter; not meant to be overridden.
    localparam int CNT_W = $clog2(STABLE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync_q;
    logic [1:0]       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             rise_reg, rise_next;
    logic             fall_reg, fall_next;

    sync_chain #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .d    (din),
        .q    (sync_q)
    );

    // The first mismatching sample counts as sample 1, so completion is
    // reached when the STABLE_CYCLES-th mismatching sample arrives with
    // cnt at STABLE_CYCLES-1. Any agreeing sample drops straight back to the
    // stable state, which restarts qualification from scratch.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        rise_next  = 1'b0;
        fall_next  = 1'b0;
        case (state_reg)
            S_LOW: begin
                if (sync_q) begin
                    state_next = S_RISE_WAIT;
                    cnt_next   = CNT_ONE;
                end else begin
                    cnt_next   = '0;
                end
            end
            S_RISE_WAIT: begin
                if (!sync_q) begin
                    state_next = S_LOW;
                    cnt_next   = '0;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = S_HIGH;
                    rise_next  = 1'b1;
                    cnt_next   = '0;
                end else begin
                    cnt_next   = cnt_reg + CNT_ONE;
                end
            end
            S_HIGH: begin
                if (!sync_q) begin
                    state_next = S_FALL_WAIT;
                    cnt_next   = CNT_ONE;
                end else begin
                    cnt_next   = '0;
                end
            end
            S_FALL_WAIT: begin
                if (sync_q) begin
                    state_next = S_HIGH;
                    cnt_next   = '0;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = S_LOW;
                    fall_next  = 1'b1;
                    cnt_next   = '0;
                end else begin
                    cnt_next   = cnt_reg + CNT_ONE;
                end
            end
            default: begin
                state_next = S_LOW;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= S_LOW;
            cnt_reg   <= '0;
            rise_reg  <= 1'b0;
            fall_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            rise_reg  <= rise_next;
            fall_reg  <= fall_next;
        end
    end

    // Level and busy are pure decodes of the registered state, so they are
    // glitch-free and change on the same edge as the pulses.
    assign dout = (state_reg == S_HIGH) || (state_reg == S_FALL_WAIT);
    assign busy = (state_reg == S_RISE_WAIT) || (state_reg == S_FALL_WAIT);
    assign rise = rise_reg;
    assign fall = fall_reg;

endmodule

// File: tb/tb_debounce_sync.sv
module tb_debounce_sync;

    logic clk;
    logic reset;
    logic din;
    logic dout;
    logic rise;
    logic fall;
    logic busy;

    int vectors;
    int miscompares;

    debounce_sync dut (
        .clk  (clk),
        .reset(reset),
        .din  (din),
        .dout (dout),
        .rise (rise),
        .fall (fall),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_outs(input string tag, input logic d, input logic r,
                            input logic f, input logic b);
        chk(tag, {4'h0, dout, rise, fall, busy}, {4'h0, d, r, f, b});
    endtask

    // din driven to 1 between edges; per-edge expectations of a clean press.
    task automatic press(input string tag);
        din = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            chk_outs($sformatf("%s_e%0d", tag, e), (e >= 6), (e == 6), 1'b0,
                     (e >= 3 && e <= 5));
        end
    endtask

    task automatic release_sw(input string tag);
        din = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            chk_outs($sformatf("%s_e%0d", tag, e), !(e >= 6), 1'b0, (e == 6),
                     (e >= 3 && e <= 5));
        end
    endtask

    initial begin
        int rise_cnt;
        int fall_cnt;
        int rise_edge;
        logic [5:0] bounce;

        vectors     = 0;
        miscompares = 0;

        // Reset asserted with a real falling edge, din toggling meanwhile.
        reset = 1'b1;
        din   = 1'b0;
        #1 reset = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            din = ~din;
            #5;
            chk_outs($sformatf("rst_hold_%0d", i), 1'b0, 1'b0, 1'b0, 1'b0);
        end
        // t = 22 ns, between edges; din is back to 0.
        reset = 1'b1;
        #1;
        chk("rst_state", {6'h0, dut.state_reg}, 8'h00);
        chk("rst_cnt", 8'(dut.cnt_reg), 8'h00);
        tick();
        tick();
        chk_outs("idle", 1'b0, 1'b0, 1'b0, 1'b0);

        press("press");
        release_sw("release");

        // Glitch: three synchronized samples of 1 fall one short.
        din = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            chk_outs($sformatf("glitch_e%0d", e), 1'b0, 1'b0, 1'b0,
                     (e >= 3 && e <= 5));
            if (e == 3) din = 1'b0;
        end

        // Bounce 1,0,1,1,0,1 then held 1; final 0->1 is before edge 6,
        // so the single rise is expected after edge 11.
        bounce    = 6'b101101;
        rise_cnt  = 0;
        fall_cnt  = 0;
        rise_edge = 0;
        for (int e = 1; e <= 16; e++) begin
            din = (e <= 6) ? bounce[6-e] : 1'b1;
            tick();
            if (rise) begin
                rise_cnt++;
                rise_edge = e;
            end
            if (fall) fall_cnt++;
            if (rise && fall) chk("rise_fall_overlap", 8'h1, 8'h0);
        end
        chk("bounce_rise_cnt", 8'(rise_cnt), 8'd1);
        chk("bounce_rise_edge", 8'(rise_edge), 8'd11);
        chk("bounce_fall_cnt", 8'(fall_cnt), 8'd0);
        chk("bounce_dout", {7'h0, dout}, 8'h1);

        release_sw("release2");

        // Reset mid-qualification: S_RISE_WAIT with cnt=2 after edge 4.
        din = 1'b1;
        for (int e = 1; e <= 4; e++) tick();
        chk("midq_state", {6'h0, dut.state_reg}, 8'h01);
        chk("midq_cnt", 8'(dut.cnt_reg), 8'h02);
        chk_outs("midq_pre", 1'b0, 1'b0, 1'b0, 1'b1);
        #2 reset = 1'b0;
        #1;
        chk_outs("midq_rst", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("midq_rst_cnt", 8'(dut.cnt_reg), 8'h00);
        tick();
        chk_outs("midq_rst_edge", 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        press("post_rst_press");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
